// File: rtl/dpsram_arb_pkg.sv
// Shared definitions for the dpsram port arbiter: FSM states, requester IDs
// and the read-latency cap.
package dpsram_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/dpsram_rr_arb2.sv
// Two-input round-robin grant. The pointer names the requester that wins the
// next contended cycle and only moves on an accepted transfer.
module dpsram_rr_arb2
  import dpsram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  logic pref_q;

  always_comb begin
    grant_o = '0;
    if (en_i) begin
      if (&valid_i) grant_o = (pref_q == REQ1) ? 2'b10 : 2'b01;
      else          grant_o = valid_i;
    end
  end

  assign grant_id_o = grant_o[1] ? REQ1 : REQ0;

  // A grant is only ever given to a valid requester, so any grant is an accept.
  always_ff @(posedge clk_i) begin
    if (rst_i)           pref_q <= REQ0;
    else if (|grant_o)   pref_q <= ~grant_id_o;
  end

endmodule

// File: rtl/dpsram_port_arbiter.sv
// Round-robin sharing of one dpsram port between two requesters, with read
// return routing and drain-then-apply handling of the datbm/cascade config.
module dpsram_port_arbiter
  import dpsram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 20,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic [DATA_W-1:0] req0_bitmask_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic [DATA_W-1:0] req1_bitmask_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [DATA_W-1:0] ram_bitmask_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              cfg_update_i,
  input  logic              cfg_datbm_sel_new_i,
  input  logic [1:0]        cfg_cascade_enable_new_i,
  output logic              cfg_datbm_sel_o,
  output logic [1:0]        cfg_cascade_enable_o,
  output logic              cfg_ack_o,
  output logic              busy_o
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
    $error("dpsram_port_arbiter: RD_LAT out of range");
  end

  state_t state_q, state_d;

  logic       arb_en;
  logic [1:0] grant;
  logic       grant_id;
  logic       ram_owner_q;

  logic [RD_LAT-1:0] rd_vld_q;
  logic [RD_LAT-1:0] rd_id_q;
  logic              rd_outstanding;

  logic       shadow_sel_q;
  logic [1:0] shadow_cas_q;

  // The update cycle itself grants nothing, so no new read can slip in behind it.
  assign arb_en = (state_q == RUN) && !cfg_update_i && !rst_i;

  dpsram_rr_arb2 u_rr_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (arb_en),
    .valid_i    ({req1_valid_i, req0_valid_i}),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  assign rd_outstanding = (ram_en_o && !ram_we_o) || (|rd_vld_q);
  assign busy_o         = (state_q != RUN) || rd_outstanding;
  assign cfg_ack_o      = (state_q == APPLY);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cfg_update_i)    state_d = DRAIN;
      DRAIN:   if (!rd_outstanding) state_d = APPLY;
      APPLY:                        state_d = RUN;
      default:                      state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q              <= RUN;
      shadow_sel_q         <= 1'b0;
      shadow_cas_q         <= '0;
      cfg_datbm_sel_o      <= 1'b0;
      cfg_cascade_enable_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && cfg_update_i) begin
        shadow_sel_q <= cfg_datbm_sel_new_i;
        shadow_cas_q <= cfg_cascade_enable_new_i;
      end
      // Loaded on the drain-complete edge so the ack cycle already shows it.
      if (state_q == DRAIN && !rd_outstanding) begin
        cfg_datbm_sel_o      <= shadow_sel_q;
        cfg_cascade_enable_o <= shadow_cas_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_en_o      <= 1'b0;
      ram_we_o      <= 1'b0;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      ram_bitmask_o <= '0;
      ram_owner_q   <= REQ0;
    end else if (|grant) begin
      ram_en_o      <= 1'b1;
      ram_we_o      <= (grant_id == REQ1) ? req1_we_i      : req0_we_i;
      ram_addr_o    <= (grant_id == REQ1) ? req1_addr_i    : req0_addr_i;
      ram_data_o    <= (grant_id == REQ1) ? req1_data_i    : req0_data_i;
      ram_bitmask_o <= (grant_id == REQ1) ? req1_bitmask_i : req0_bitmask_i;
      ram_owner_q   <= grant_id;
    end else begin
      ram_en_o <= 1'b0;
      ram_we_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q     <= '0;
      rd_id_q      <= '0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp_rdata_o  <= '0;
    end else begin
      rd_vld_q[0] <= ram_en_o && !ram_we_o;
      rd_id_q[0]  <= ram_owner_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
      rsp0_valid_o <= rd_vld_q[RD_LAT-1] && (rd_id_q[RD_LAT-1] == REQ0);
      rsp1_valid_o <= rd_vld_q[RD_LAT-1] && (rd_id_q[RD_LAT-1] == REQ1);
      if (rd_vld_q[RD_LAT-1]) rsp_rdata_o <= ram_rdata_i;
    end
  end

endmodule

// File: doc/dpsram_port_arbiter.md
Name: dpsram_port_arbiter

Overview:
- Shares the single port of one 512x20 dpsram block between two requesters (req0, req1) using round-robin arbitration.
- Registers the winning access onto the RAM port and routes registered read data back to the requester that issued the read.
- Owns the data/bitmask-select and cascade configuration that feeds the forward data/bitmask selection stage. New values are applied only after the port is drained, so no access ever sees a half-changed configuration.

Parameters:
ADDR_W, 9, RAM word address width (512 words)
DATA_W, 20, data and bitmask width
RD_LAT, 1, cycles from ram_en_o/!ram_we_o to valid ram_rdata_i; legal 1..3

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
reqN_valid_i  in  1  request valid, N=0,1
reqN_ready_o  out  1  request accepted this cycle when valid&ready
reqN_we_i  in  1  1=write, 0=read
reqN_addr_i  in  ADDR_W  word address
reqN_data_i  in  DATA_W  write data
reqN_bitmask_i  in  DATA_W  write bitmask
rspN_valid_o  out  1  read data for requester N valid this cycle
rsp_rdata_o  out  DATA_W  read data, shared by both requesters
ram_en_o  out  1  RAM access strobe
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM address
ram_data_o  out  DATA_W  RAM write data
ram_bitmask_o  out  DATA_W  RAM write bitmask
ram_rdata_i  in  DATA_W  RAM read data
cfg_update_i  in  1  one-cycle pulse: apply cfg_*_new_i
cfg_datbm_sel_new_i  in  1  requested datbm select
cfg_cascade_enable_new_i  in  2  requested cascade enable
cfg_datbm_sel_o  out  1  active datbm select
cfg_cascade_enable_o  out  2  active cascade enable
cfg_ack_o  out  1  one-cycle pulse: new config active
busy_o  out  1  state!=RUN or read outstanding

Behaviour:
- Clock and reset: one clock (clk_i); reset synchronous, active-high (rst_i).
- Reset values:
  - All outputs 0.
  - State RUN; round-robin pointer favours req0 first.
  - Read-owner pipe empty; pending-config flag clear.
- FSM states RUN, DRAIN, APPLY.
  - RUN: arbitrate. cfg_update_i captures cfg_*_new_i into shadow registers and moves to DRAIN at the next edge. No grant in the cycle cfg_update_i is high.
  - DRAIN: both ready_o=0. Stay until the read-owner pipe is empty, then go to APPLY.
  - APPLY (1 cycle): cfg_*_o <= shadow values, cfg_ack_o=1, then RUN.
  - cfg_update_i outside RUN is ignored. No queueing.
- Arbitration (RUN only):
  - Only one requester valid: it gets ready=1.
  - Both valid: grant goes to the one not granted last.
  - Pointer updates only on an accepted transfer.
  - ready_o is combinational from valid_i, pointer and state. At most one ready per cycle.
- Issue:
  - An accepted request appears on ram_* exactly 1 cycle later, with ram_en_o=1 for one cycle.
  - Back-to-back acceptance gives one access per cycle.
  - When ram_en_o=0, ram_we_o=0 and addr/data/bitmask hold their last values.
- Reads:
  - The owner ID is pushed into an RD_LAT-deep shift pipe.
  - rspN_valid_o and rsp_rdata_o are registered and asserted RD_LAT+1 cycles after the ram_en_o cycle, i.e. ram_rdata_i is sampled RD_LAT cycles after ram_en_o.
  - Writes produce no response.
- Configuration changes never overlap an in-flight read. Writes issued before DRAIN complete normally.
- Reset mid-operation: in-flight reads are dropped (no rsp_valid), shadow config is discarded, cfg_*_o return to 0.

Decomposition:
- Shared package dpsram_arb_pkg holds:
  - state encoding (RUN=2'd0, DRAIN=2'd1, APPLY=2'd2);
  - requester ID constants REQ0=1'b0, REQ1=1'b1;
  - a defined cap for RD_LAT (3).
- One natural sub-module: dpsram_rr_arb2, the 2-input round-robin grant with pointer register.

Test Plan:
- Only req0 valid, write addr 0x1A5, data 0xABCDE, bitmask 0xFFFFF -> ready0=1 same cycle; next cycle ram_en=1, we=1, addr=0x1A5, data=0xABCDE.
- req0 and req1 valid for 4 cycles after reset -> grants 0,1,0,1; ram_addr sequence matches; no idle cycles.
- req1 reads addr 0x010, RAM model returns 0x12345 with RD_LAT=2 -> rsp1_valid=1, rsp_rdata=0x12345 three cycles after ram_en; rsp0_valid stays 0.
- Read issued, then cfg_update_i with datbm_sel=1, cascade=2'b10 the next cycle -> ready held 0 until response returns; then cfg_ack_o pulses once; cfg_datbm_sel_o=1, cfg_cascade_enable_o=2'b10; arbitration resumes the following cycle.
- rst_i asserted one cycle after a read issue -> no rsp_valid ever; all outputs 0 next cycle; first post-reset contention granted to req0.
- cfg_update_i pulsed during DRAIN with different values -> ignored; applied config equals the first captured values.
